// File: rtl/bp_common_rv64_pkg.sv
// Shared RV64 definitions: instruction layouts, opcode constants and the
// encoder descriptor format enum used by the backend instruction encoder.
package bp_common_rv64_pkg;

  localparam int rv64_instr_width_gp = 32;

  // Descriptor formats accepted by the encoder
  typedef enum logic [2:0] {
    e_enc_r  = 3'd0,
    e_enc_i  = 3'd1,
    e_enc_s  = 3'd2,
    e_enc_u  = 3'd3,
    e_enc_li = 3'd4
  } bp_be_enc_fmt_e;

  // Encoder FSM states
  typedef enum logic {
    e_idle  = 1'b0,
    e_li_lo = 1'b1
  } bp_be_enc_state_e;

  localparam logic [6:0] rv64_op_imm    = 7'b0010011;
  localparam logic [6:0] rv64_op_imm_32 = 7'b0011011;
  localparam logic [6:0] rv64_op_lui    = 7'b0110111;
  localparam logic [2:0] rv64_funct3_addi  = 3'b000;
  localparam logic [2:0] rv64_funct3_addiw = 3'b000;
  localparam logic [31:0] rv64_nop_instr = 32'h0000_0013;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv64_instr_rtype_s;

  typedef struct packed {
    logic [11:0] imm12;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } rv64_instr_itype_s;

  typedef struct packed {
    logic [6:0] imm11to5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm4to0;
    logic [6:0] opcode;
  } rv64_instr_stype_s;

  typedef struct packed {
    logic [19:0] imm20;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } rv64_instr_utype_s;

  // One 32-bit instruction word seen through each format view
  typedef union packed {
    rv64_instr_rtype_s rtype;
    rv64_instr_itype_s itype;
    rv64_instr_stype_s stype;
    rv64_instr_utype_s utype;
  } rv64_instr_s;

  function automatic rv64_instr_s make_itype(input logic [11:0] imm12,
                                             input logic [4:0]  rs1,
                                             input logic [2:0]  funct3,
                                             input logic [4:0]  rd,
                                             input logic [6:0]  opcode);
    rv64_instr_s w;
    w.itype = '{imm12: imm12, rs1: rs1, funct3: funct3, rd: rd, opcode: opcode};
    return w;
  endfunction

  function automatic rv64_instr_s make_utype(input logic [19:0] imm20,
                                             input logic [4:0]  rd,
                                             input logic [6:0]  opcode);
    rv64_instr_s w;
    w.utype = '{imm20: imm20, rd: rd, opcode: opcode};
    return w;
  endfunction

endpackage

// File: rtl/bp_be_li_split.sv
// Splits a 32-bit li immediate into the LUI/ADDIW pieces and classifies
// whether a single instruction is enough.
module bp_be_li_split
  import bp_common_rv64_pkg::*;
(
  input  logic [31:0] imm_i,
  output logic        single_o,
  output logic        use_lui_only_o,
  output logic [19:0] hi20_o,
  output logic [11:0] lo12_o
);

  logic fits12;
  logic lo_zero;

  // Classify the immediate and round the upper part for a signed low half
  always_comb begin
    fits12         = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    lo_zero        = (imm_i[11:0] == 12'd0);
    lo12_o         = imm_i[11:0];
    // (imm + 0x800)[31:12]: the low half is sign-extended by ADDIW, so round up
    // when bit 11 is set. Wraps to 20'h80000 for 0x7FFFF800.., which ADDIW fixes.
    hi20_o         = imm_i[31:12] + {19'd0, imm_i[11]};
    single_o       = fits12 | lo_zero;
    use_lui_only_o = ~fits12 & lo_zero;
  end

endmodule

// File: rtl/bp_be_instr_encoder.sv
// Streaming RV64 instruction encoder: packs R/I/S/U descriptors into 32-bit
// words and expands li into LUI/ADDIW. Output is a single registered stage.
//
// Handshake: a descriptor is taken when v_i & ready_o; an instruction moves
// when v_o & ready_and_i. instr_o holds steady while v_o & ~ready_and_i.
// ready_o drops during the second half of a two-word li.
module bp_be_instr_encoder
  import bp_common_rv64_pkg::*;
#(
  parameter int instr_width_p = 32,
  parameter int imm_width_p   = 32
)
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [2:0]               fmt_i,
  input  logic [6:0]               opcode_i,
  input  logic [2:0]               funct3_i,
  input  logic [6:0]               funct7_i,
  input  logic [4:0]               rd_i,
  input  logic [4:0]               rs1_i,
  input  logic [4:0]               rs2_i,
  input  logic [imm_width_p-1:0]   imm_i,
  output logic                     v_o,
  input  logic                     ready_and_i,
  output logic [instr_width_p-1:0] instr_o,
  output logic                     error_o
);

  bp_be_enc_state_e state_r, state_n;
  rv64_instr_s      instr_r, instr_n;
  logic             v_r, v_n;
  logic             err_r, err_n;
  logic [11:0]      lo12_r, lo12_n;
  logic [4:0]       rd_r, rd_n;

  rv64_instr_s      desc_word;
  logic             desc_err;
  logic             desc_two;
  logic             imm_fits12;
  logic             accept;
  logic             out_xfer;

  logic             li_single;
  logic             li_lui_only;
  logic [19:0]      li_hi20;
  logic [11:0]      li_lo12;

  bp_be_li_split li_split (
    .imm_i          (imm_i[31:0]),
    .single_o       (li_single),
    .use_lui_only_o (li_lui_only),
    .hi20_o         (li_hi20),
    .lo12_o         (li_lo12)
  );

  assign ready_o  = (state_r == e_idle) & (~v_r | ready_and_i);
  assign accept   = v_i & ready_o;
  assign out_xfer = v_r & ready_and_i;
  assign v_o      = v_r;
  assign instr_o  = instr_r;
  assign error_o  = err_r;

  // Pack the incoming descriptor into its first (often only) instruction word
  always_comb begin
    desc_word  = '0;
    desc_err   = 1'b0;
    desc_two   = 1'b0;
    imm_fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    case (bp_be_enc_fmt_e'(fmt_i))
      e_enc_r: desc_word.rtype = '{funct7: funct7_i, rs2: rs2_i, rs1: rs1_i,
                                   funct3: funct3_i, rd: rd_i, opcode: opcode_i};
      e_enc_i: begin
        desc_word = make_itype(imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i);
        desc_err  = ~imm_fits12;
      end
      e_enc_s: begin
        desc_word.stype = '{imm11to5: imm_i[11:5], rs2: rs2_i, rs1: rs1_i,
                            funct3: funct3_i, imm4to0: imm_i[4:0], opcode: opcode_i};
        desc_err        = ~imm_fits12;
      end
      e_enc_u: desc_word = make_utype(imm_i[31:12], rd_i, opcode_i);
      e_enc_li: begin
        if (rd_i == 5'd0) begin
          desc_word = rv64_nop_instr;
        end else if (li_single & ~li_lui_only) begin
          desc_word = make_itype(imm_i[11:0], 5'd0, rv64_funct3_addi, rd_i, rv64_op_imm);
        end else begin
          // LUI-only case has imm[11]=0, so hi20 equals imm[31:12] there
          desc_word = make_utype(li_hi20, rd_i, rv64_op_lui);
          desc_two  = ~li_single;
        end
      end
      // Unknown format codes are rejected like an out-of-range immediate
      default: desc_err = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // Next-state: enter e_li_lo after a two-word li, leave once the LUI moves
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:  if (accept & ~desc_err & desc_two) state_n = e_li_lo;
      e_li_lo: if (out_xfer) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  // Output-stage next values: load on accept or ADDIW follow-up, clear on transfer
  always_comb begin
    instr_n = instr_r;
    v_n     = v_r;
    err_n   = 1'b0;
    lo12_n  = lo12_r;
    rd_n    = rd_r;
    if (out_xfer) v_n = 1'b0;
    case (state_r)
      e_idle: begin
        if (accept) begin
          if (desc_err) begin
            err_n = 1'b1;
          end else begin
            instr_n = desc_word;
            v_n     = 1'b1;
            lo12_n  = li_lo12;
            rd_n    = rd_i;
          end
        end
      end
      e_li_lo: begin
        if (out_xfer) begin
          instr_n = make_itype(lo12_r, rd_r, rv64_funct3_addiw, rd_r, rv64_op_imm_32);
          v_n     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output register and the saved second half of a two-word li
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      instr_r <= '0;
      v_r     <= 1'b0;
      err_r   <= 1'b0;
      lo12_r  <= '0;
      rd_r    <= '0;
    end else begin
      instr_r <= instr_n;
      v_r     <= v_n;
      err_r   <= err_n;
      lo12_r  <= lo12_n;
      rd_r    <= rd_n;
    end
  end

endmodule

// File: tb/tb_bp_be_instr_encoder.sv
// Directed bench for bp_be_instr_encoder with hand-computed instruction words.
module tb_bp_be_instr_encoder;
  import bp_common_rv64_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        v_o;
  logic        ready_and_i;
  logic [31:0] instr_o;
  logic        error_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  bp_be_instr_encoder dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .ready_o     (ready_o),
    .fmt_i       (fmt_i),
    .opcode_i    (opcode_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .imm_i       (imm_i),
    .v_o         (v_o),
    .ready_and_i (ready_and_i),
    .instr_o     (instr_o),
    .error_o     (error_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard: the transfer happens at the next posedge, inputs are stable here
  always @(negedge clk) begin
    if (!reset_i && v_o && ready_and_i) begin
      if (exp_q.size() == 0) check("unexpected_xfer", 32'(exp_q.size()), 32'd1);
      else check("xfer_instr", instr_o, exp_q.pop_front());
    end
  end

  // Driver: present a descriptor and return #1 after the edge that takes it
  task automatic send(input bp_be_enc_fmt_e fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int cnt = 0;
    fmt_i = fmt; opcode_i = op; funct3_i = f3; funct7_i = f7;
    rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    v_i = 1'b1;
    while (!ready_o && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!ready_o) check("send_timeout", 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    v_i = 1'b0;
  endtask

  task automatic li(input logic [4:0] rd, input logic [31:0] imm);
    send(e_enc_li, 7'd0, 3'd0, 7'd0, rd, 5'd0, 5'd0, imm);
  endtask

  // Let the output stage empty with the consumer ready
  task automatic drain();
    int cnt = 0;
    ready_and_i = 1'b1;
    while ((v_o || !ready_o) && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("drain_done", 32'(v_o), 32'd0);
  endtask

  initial begin
    // Reset
    reset_i = 1'b1; v_i = 1'b0; ready_and_i = 1'b1;
    fmt_i = '0; opcode_i = '0; funct3_i = '0; funct7_i = '0;
    rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_v_o", 32'(v_o), 32'd0);
    check("rst_instr_o", instr_o, 32'd0);
    check("rst_error_o", 32'(error_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    reset_i = 1'b0;
    @(posedge clk); #1;

    // add x3,x1,x2: visible one cycle after accept
    exp_q.push_back(32'h002081B3);
    send(e_enc_r, 7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    check("r_v_o", 32'(v_o), 32'd1);
    check("r_instr", instr_o, 32'h002081B3);

    // Back-to-back I/S/S/U at one per cycle
    exp_q.push_back(32'hFFF10093);  // addi x1,x2,-1
    send(e_enc_i, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
    check("i_instr", instr_o, 32'hFFF10093);
    exp_q.push_back(32'h0020B423);  // sd x2,8(x1)
    send(e_enc_s, 7'b0100011, 3'b011, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    exp_q.push_back(32'hFE512823);  // sw x5,-16(x2)
    send(e_enc_s, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFF0);
    exp_q.push_back(32'hABCDE397);  // auipc x7,0xABCDE
    send(e_enc_u, 7'b0010111, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'hABCD_E000);
    check("u_instr", instr_o, 32'hABCDE397);

    // Two-word li: ready_o low until the ADDIW loads
    exp_q.push_back(32'h123452B7);
    exp_q.push_back(32'h6782829B);
    li(5'd5, 32'h1234_5678);
    check("li_lui", instr_o, 32'h123452B7);
    check("li_ready_low", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    check("li_addiw", instr_o, 32'h6782829B);
    check("li_ready_back", 32'(ready_o), 32'd1);

    // hi20 wraps to 0x80000
    exp_q.push_back(32'h800002B7);
    exp_q.push_back(32'h8002829B);
    li(5'd5, 32'h7FFF_F800);
    // Single-word li forms
    exp_q.push_back(32'hFFB00293);
    li(5'd5, 32'hFFFF_FFFB);
    check("li_addi", instr_o, 32'hFFB00293);
    exp_q.push_back(32'h000102B7);
    li(5'd5, 32'h0001_0000);
    check("li_lui_only", instr_o, 32'h000102B7);
    exp_q.push_back(32'h00000013);
    li(5'd0, 32'h1234_5678);
    check("li_x0_nop", instr_o, 32'h00000013);
    drain();

    // Out-of-range I immediate: error pulse, no output
    send(e_enc_i, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048);
    check("i_err_pulse", 32'(error_o), 32'd1);
    check("i_err_no_v", 32'(v_o), 32'd0);
    @(posedge clk); #1;
    check("i_err_one_cycle", 32'(error_o), 32'd0);
    exp_q.push_back(32'hFFF10093);
    send(e_enc_i, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
    check("i_after_err", instr_o, 32'hFFF10093);
    // S reject while the previous word transfers in the same cycle
    send(e_enc_s, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_F7FF);
    check("s_err_pulse", 32'(error_o), 32'd1);
    check("s_err_v_cleared", 32'(v_o), 32'd0);
    drain();

    // Backpressure mid-li
    ready_and_i = 1'b0;
    exp_q.push_back(32'h123452B7);
    exp_q.push_back(32'h6782829B);
    li(5'd5, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      check("bp_instr_stable", instr_o, 32'h123452B7);
      check("bp_ready_low", 32'(ready_o), 32'd0);
      @(posedge clk); #1;
    end
    drain();
    check("bp_final_addiw", instr_o, 32'h6782829B);

    // Async reset while waiting in e_li_lo: the ADDIW half is dropped
    ready_and_i = 1'b0;
    li(5'd5, 32'h7FFF_F800);
    check("rst_li_lui", instr_o, 32'h800002B7);
    #2;
    reset_i = 1'b1;
    #1;
    check("rst_async_v_o", 32'(v_o), 32'd0);
    check("rst_async_instr", instr_o, 32'd0);
    ready_and_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_addiw", 32'(v_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_be_instr_encoder.md
Name: bp_be_instr_encoder

Overview:
- Streaming RV64 instruction encoder, the inverse of the backend decode path.
- Packs field descriptors into 32-bit R/I/S/U-format instruction words.
- Expands the "li rd, imm32" pseudo-op into a 1- or 2-instruction LUI/ADDIW sequence.
- Sits between a debug/boot instruction injector and the fetch-bypass path, with a valid/ready handshake on each side.

Parameters:
- instr_width_p, 32, output instruction width (rv64_instr_width_gp)
- imm_width_p, 32, descriptor immediate width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; one clock; reset is asynchronous and active-high
- v_i  in  1  descriptor valid
- ready_o  out  1  encoder accepts descriptor this cycle
- fmt_i  in  3  bp_be_enc_fmt_e: e_enc_r, e_enc_i, e_enc_s, e_enc_u, e_enc_li
- opcode_i  in  7  opcode (ignored for li)
- funct3_i  in  3  funct3 (ignored for u/li)
- funct7_i  in  7  funct7 (r only)
- rd_i  in  5  rd
- rs1_i  in  5  rs1
- rs2_i  in  5  rs2
- imm_i  in  32  immediate: I/S/li use signed imm_i; U uses imm_i[31:12]
- v_o  out  1  instruction valid
- ready_and_i  in  1  consumer ready
- instr_o  out  32  encoded instruction (rv64_instr_s layout)
- error_o  out  1  one-cycle pulse when a descriptor is rejected

Behaviour:
- Reset (async): state=e_idle, v_o=0, instr_o=0, error_o=0. Reset mid-li drops the second half.
- Handshake:
  - Input accepted when v_i & ready_o.
  - Output transfer occurs when v_o & ready_and_i.
  - instr_o is stable while v_o & ~ready_and_i.
- ready_o = (state==e_idle) & (~v_o | ready_and_i). This allows back-to-back streaming at 1 instr/cycle.
- Latency: instr_o is registered; a descriptor accepted in cycle N yields v_o in N+1.
- States:
  - e_idle: accept a descriptor.
    - Single-word result: load the output register, stay in e_idle.
    - Two-word li: load the LUI word, go to e_li_lo.
  - e_li_lo: when the LUI word transfers, load ADDIW rd,rd,lo12 and return to e_idle. ready_o=0 throughout.
- Format packing:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}.
  - I: {imm[11:0],rs1,funct3,rd,opcode}.
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
  - U: {imm[31:12],rd,opcode}.
- Range check (I, S):
  - Condition: imm_i[31:11] must be all-equal (fits signed 12).
  - On failure: no output, error_o pulses in N+1, v_o is unchanged.
  - The descriptor is still consumed (ready_o unaffected).
- li expansion, with lo12=imm[11:0] and hi20=(imm+32'h800)[31:12] (32-bit wraparound):
  - rd==0: single NOP (ADDI x0,x0,0 = 32'h00000013).
  - imm fits signed 12: single ADDI rd,x0,imm.
  - lo12==0: single LUI rd,imm[31:12].
  - otherwise: LUI rd,hi20 followed by ADDIW rd,rd,lo12.
  - ADDIW is mandatory so the RV64 result equals sign-extended imm32; hi20 overflow to 20'h80000 is correct under ADDIW.
- Simultaneous events: an output transfer and a new accept in the same cycle are legal; the register reloads.
- error_o never coincides with a new v_o edge from the same descriptor.

Decomposition:
- Shared package (bp_common_rv64_pkg), add:
  - bp_be_enc_fmt_e
  - opcode constants rv64_op_imm (7'b0010011), rv64_op_imm_32 (7'b0011011), rv64_op_lui (7'b0110111)
  - funct3 constant addi/addiw (3'b000)
  - rv64_nop_instr constant
- Reuse rv64_instr_s and its rtype/itype/stype/utype views for packing.
- One combinational sub-module, bp_be_li_split: imm32 -> {single, use_lui_only, hi20, lo12}. The FSM, range check and output register stay in the top.

Test Plan:
- R add x3,x1,x2 (funct7=0, funct3=0, opcode=0110011), ready_and_i=1 -> instr_o=32'h002081B3, v_o high one cycle after accept.
- li x5,32'h12345678 -> LUI 32'h123452B7, then ADDIW 32'h6782829B; ready_o low until the ADDIW loads.
- li x5,32'h7FFFF800 -> LUI x5,20'h80000 (32'h800002B7), then ADDIW x5,x5,-2048 (32'h8002829B).
- li x5,-5 -> single ADDI 32'hFFB00293; li x5,32'h00010000 -> single LUI 32'h000102B7; li x0,anything -> 32'h00000013.
- I-format imm_i=2048 -> error_o pulses one cycle, v_o stays 0, next descriptor is accepted normally.
- Backpressure: hold ready_and_i=0 for 5 cycles mid-li -> instr_o stable, ready_o=0. Assert reset_i asynchronously in e_li_lo -> v_o=0 immediately and no ADDIW is emitted after reset release.
